// File: rtl/decode_pkg.sv
// Shared opcode map, control-bit indices, instruction field positions and
// destination-decode helpers for the decode stage.
package decode_pkg;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_LI  = 6'd2;
  localparam logic [5:0] OP_SHL = 6'd3;
  localparam logic [5:0] OP_SHR = 6'd4;
  localparam logic [5:0] OP_AND = 6'd5;
  localparam logic [5:0] OP_OR  = 6'd6;
  localparam logic [5:0] OP_XOR = 6'd7;
  localparam logic [5:0] OP_BR  = 6'd8;
  localparam logic [5:0] OP_BNE = 6'd9;
  localparam logic [5:0] OP_MOV = 6'd10;
  localparam logic [5:0] OP_ADI = 6'd11;
  localparam logic [5:0] OP_MUL = 6'd12;
  localparam logic [5:0] OP_HLT = 6'd13;
  localparam logic [5:0] OP_NOP = 6'd14;
  localparam logic [5:0] OP_FIRST_ILLEGAL = 6'd15;

  localparam int CTRL_W   = 16;
  localparam int CTRL_ADD = 0;
  localparam int CTRL_SUB = 1;
  localparam int CTRL_LI  = 2;
  localparam int CTRL_SHL = 3;
  localparam int CTRL_SHR = 4;
  localparam int CTRL_AND = 5;
  localparam int CTRL_OR  = 6;
  localparam int CTRL_XOR = 7;
  localparam int CTRL_BR  = 8;
  localparam int CTRL_BNE = 9;
  localparam int CTRL_MOV = 10;
  localparam int CTRL_ADI = 11;
  localparam int CTRL_MUL = 12;
  localparam int CTRL_HLT = 13;
  localparam int CTRL_NOP = 14;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  function automatic logic has_dest(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_LI, OP_SHL, OP_SHR, OP_AND, OP_OR,
      OP_XOR, OP_MOV, OP_ADI, OP_MUL: has_dest = 1'b1;
      default:                        has_dest = 1'b0;
    endcase
  endfunction

  // 1: destination comes from the rt field, 0: from the rd field
  function automatic logic dest_sel(input logic [5:0] op);
    dest_sel = (op == OP_LI) || (op == OP_ADI);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file; a same-cycle write is forwarded to both
// read ports so the reader never sees the stale value.
module regfile_2r1w #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter bit ZERO_R0 = 1'b1,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RW-1:0]     raddr_a,
  input  logic [RW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_en;

  assign wr_en = we && !(ZERO_R0 && (waddr == '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    if (ZERO_R0 && (raddr_a == '0))    rdata_a = '0;
    else if (wr_en && waddr == raddr_a) rdata_a = wdata;
    else                                rdata_a = mem[raddr_a];
    if (ZERO_R0 && (raddr_b == '0))    rdata_b = '0;
    else if (wr_en && waddr == raddr_b) rdata_b = wdata;
    else                                rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage between IF/ID and ID/EX: register read, load-use scoreboard,
// flush and a RUN/HALT state machine; halted reflects the FSM state.
// Handshake: a transfer happens on a side when valid & ready are both high
// at a rising edge; if_ready never depends on if_valid, and ex_* stay stable
// while ex_valid & !ex_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int NREGS   = 32,
  parameter bit ZERO_R0 = 1'b1,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [31:0]       ex_instr,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [15:0]       ex_ctrl,
  output logic              ex_illegal,
  output logic              halted
);

  logic [5:0]        op;
  logic [4:0]        rs_f, rt_f, rd_f;
  logic [15:0]       imm_f;
  logic [RW-1:0]     rs_idx, rt_idx, dst_idx;
  logic              dst_v;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [15:0]       ctrl_nx;
  logic              illegal_nx;
  logic              hazard, ld, run;
  logic [NREGS-1:0]  pending, pend_set, pend_clr;
  logic              ex_dest_v;
  logic [RW-1:0]     ex_dest;
  state_t            state, state_nx;

  assign op     = if_instr[OP_HI:OP_LO];
  assign rs_f   = if_instr[RS_HI:RS_LO];
  assign rt_f   = if_instr[RT_HI:RT_LO];
  assign rd_f   = if_instr[RD_HI:RD_LO];
  assign imm_f  = if_instr[IMM_HI:IMM_LO];
  assign rs_idx = rs_f[RW-1:0];
  assign rt_idx = rt_f[RW-1:0];
  assign dst_idx = dest_sel(op) ? rt_f[RW-1:0] : rd_f[RW-1:0];
  assign dst_v   = has_dest(op) && !(ZERO_R0 && (dst_idx == '0));

  assign illegal_nx = (op >= OP_FIRST_ILLEGAL);
  always_comb begin
    ctrl_nx = '0;
    if (!illegal_nx) ctrl_nx[op[3:0]] = 1'b1;
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ZERO_R0(ZERO_R0)
  ) u_rf (
    .clock  (clock),
    .reset  (reset),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr_a(rs_idx),
    .raddr_b(rt_idx),
    .rdata_a(rs_val),
    .rdata_b(rt_val)
  );

  // A write-back landing this cycle resolves the dependency immediately.
  assign hazard = (pending[rs_idx] && !(wb_valid && wb_rd == rs_idx)) ||
                  (pending[rt_idx] && !(wb_valid && wb_rd == rt_idx));
  assign if_ready = run && (!ex_valid || ex_ready) && !hazard && !flush;
  assign ld       = if_valid && if_ready;

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (wb_valid) pend_clr[wb_rd] = 1'b1;
    if (flush && ex_valid && ex_dest_v) pend_clr[ex_dest] = 1'b1;
    if (ld && dst_v) pend_set[dst_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_instr   <= '0;
      ex_pc      <= '0;
      ex_rs_val  <= '0;
      ex_rt_val  <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
      ex_illegal <= 1'b0;
      ex_dest_v  <= 1'b0;
      ex_dest    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ld) begin
      ex_valid   <= 1'b1;
      ex_instr   <= if_instr;
      ex_pc      <= if_pc;
      ex_rs_val  <= rs_val;
      ex_rt_val  <= rt_val;
      ex_imm     <= DATA_W'($signed(imm_f));
      ex_ctrl    <= ctrl_nx;
      ex_illegal <= illegal_nx;
      ex_dest_v  <= dst_v;
      ex_dest    <= dst_idx;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_RUN;
    else       state <= state_nx;
  end

  // ld already excludes flush, so a flush alongside HLT keeps RUN.
  always_comb begin
    state_nx = state;
    if (state == S_RUN && ld && op == OP_HLT) state_nx = S_HALT;
  end

  always_comb begin
    run    = (state == S_RUN);
    halted = (state == S_HALT);
  end

endmodule
